// File: rtl/tt_sumlatch_pkg.sv
// Shared definitions for the SumLatchUART design.
// Holds the default UART bit period, the transmitter state type and
// the widths of the latched sum and of the UART data byte.
package tt_sumlatch_pkg;

  // 50 MHz clock / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 434;

  localparam int SUM_W  = 5;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/tt_um_top_uart_tx.sv
// 8N1 UART transmitter.
// Ports:
//   clk, rst_n   - clock and asynchronous active-low reset
//   start        - load data and begin a frame (honoured only when idle)
//   data[7:0]    - byte to send, LSB first
//   tx           - serial line, idles high
//   busy         - high from the start bit through the stop bit
module uart_tx
  import tt_sumlatch_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              tx,
  output logic              busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              bit_done;

  assign bit_done = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    cnt_d     = bit_done ? '0 : cnt_q + 1'b1;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          state_d = START;
          shift_d = data;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            // shift register keeps the bit being sent in position 0
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: rtl/tt_um_top.sv
// Tiny Tapeout top for SumLatchUART.
// Adds ui_in[3:0] and ui_in[7:4], latches the 5-bit sum on a synchronized
// rising edge of uio_in[0] and sends it as one UART byte.
// Ports:
//   ui_in[3:0] A, ui_in[7:4] B, uio_in[0] latch strobe (asynchronous)
//   uo_out[4:0] latched sum, [5] tx_busy, [6] 0, [7] uart_tx
//   uio_out / uio_oe tied to zero (all bidirectional pins are inputs)
module tt_um_top
  import tt_sumlatch_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             s3_q, s3_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W-1:0] sum_now;
  logic             rise;
  logic             accept;
  logic             tx_busy;
  logic             uart_tx_line;
  logic             unused_inputs;

  assign unused_inputs = &{1'b0, ena, uio_in[7:1]};

  assign sum_now = SUM_W'(ui_in[3:0]) + SUM_W'(ui_in[7:4]);
  assign rise    = s2_q & ~s3_q;
  // A strobe arriving while a frame is in flight is dropped, not queued.
  assign accept  = rise & ~tx_busy;

  always_comb begin
    s1_d  = uio_in[0];
    s2_d  = s1_q;
    s3_d  = s2_q;
    sum_d = accept ? sum_now : sum_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      sum_q <= '0;
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      sum_q <= sum_d;
    end
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .start(accept),
    .data (DATA_W'(sum_now)),
    .tx   (uart_tx_line),
    .busy (tx_busy)
  );

  assign uo_out  = {uart_tx_line, 1'b0, tx_busy, sum_q};
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_top.sv
// Testbench for tt_um_top with CLKS_PER_BIT = 8.
module tb_tt_um_top;

  localparam int CPB   = 8;
  localparam int HALF  = CPB / 2;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;
  int hold_left = 0;

  tt_um_top #(.CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; releases the strobe after its hold time.
  task automatic step();
    @(negedge clk);
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) uio_in[0] = 1'b0;
    end
  endtask

  // Raise the strobe (len cycles, 0 = keep high) and wait for the start bit.
  task automatic strobe_and_wait(input logic [7:0] ui, input int len, input string tag);
    int n;
    int exp_sum;
    n = 0;
    exp_sum = int'(ui[3:0]) + int'(ui[7:4]);
    ui_in = ui;
    uio_in[0] = 1'b1;
    hold_left = len;
    while (uo_out[7] !== 1'b0 && n < 8) begin
      step();
      n++;
    end
    check($sformatf("%s_latency", tag), 32'(n), 32'd3);
    check($sformatf("%s_sum", tag), 32'(uo_out[4:0]), 32'(exp_sum));
    check($sformatf("%s_busy", tag), 32'(uo_out[5]), 32'd1);
  endtask

  // Decode one frame whose start bit was just seen; optionally restrobe mid-frame.
  task automatic run_frame(input logic [7:0] exp_byte, input string tag,
                           input int restrobe_at, input logic [7:0] restrobe_ui);
    logic [7:0] rx;
    int k;
    rx = 8'h00;
    for (int c = 1; c <= FRAME; c++) begin
      step();
      if (c == restrobe_at) begin
        ui_in = restrobe_ui;
        uio_in[0] = 1'b1;
        hold_left = 4;
      end
      if (c >= HALF && ((c - HALF) % CPB) == 0) begin
        k = (c - HALF) / CPB;
        if (k == 0) check($sformatf("%s_startbit", tag), 32'(uo_out[7]), 32'd0);
        else if (k <= 8) rx[k-1] = uo_out[7];
        else check($sformatf("%s_stopbit", tag), 32'(uo_out[7]), 32'd1);
      end
      if (c == FRAME - 1) check($sformatf("%s_busy_end", tag), 32'(uo_out[5]), 32'd1);
      if (c == FRAME)     check($sformatf("%s_busy_fall", tag), 32'(uo_out[5]), 32'd0);
    end
    check($sformatf("%s_byte", tag), 32'(rx), 32'(exp_byte));
    check($sformatf("%s_uo_after", tag), 32'(uo_out), 32'(8'h80 | {3'b000, exp_byte[4:0]}));
  endtask

  // Expect the line to stay idle for n cycles.
  task automatic wait_quiet(input int n, input string tag);
    logic saw;
    saw = 1'b0;
    for (int i = 0; i < n; i++) begin
      step();
      if (uo_out[7] !== 1'b1) saw = 1'b1;
    end
    check($sformatf("%s_no_frame", tag), 32'(saw), 32'd0);
  endtask

  initial begin
    logic [3:0] a;
    logic [3:0] b;
    int len;

    // Reset
    rst_n = 1'b0;
    repeat (5) step();
    check("reset_uo_held", 32'(uo_out), 32'h80);
    rst_n = 1'b1;
    step();
    check("reset_uo", 32'(uo_out), 32'h80);
    check("reset_uio_oe", 32'(uio_oe), 32'h00);
    check("reset_uio_out", 32'(uio_out), 32'h00);
    wait_quiet(10, "reset");

    // Basic sum 3 + 5
    strobe_and_wait(8'h53, 4, "basic");
    run_frame(8'h08, "basic", -1, 8'h00);
    step();

    // Maximum 15 + 15
    strobe_and_wait(8'hFF, 4, "max");
    run_frame(8'h1E, "max", -1, 8'h00);
    step();

    // Busy lockout: second strobe mid-frame is dropped
    strobe_and_wait(8'h11, 4, "lock");
    run_frame(8'h02, "lock", 30, 8'h77);
    wait_quiet(200, "lock");
    check("lock_sum_kept", 32'(uo_out), 32'h82);

    // Held strobe: only one event for 300 cycles high
    strobe_and_wait(8'h21, 0, "held");
    run_frame(8'h03, "held", -1, 8'h00);
    wait_quiet(300 - 3 - FRAME, "held_high");
    uio_in[0] = 1'b0;
    wait_quiet(200, "held_low");
    check("held_uo", 32'(uo_out), 32'h83);

    // Mid-frame reset
    strobe_and_wait(8'h44, 4, "midrst");
    for (int c = 1; c <= 40; c++) step();
    check("midrst_in_frame", 32'(uo_out[5]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_tx_async", 32'(uo_out[7]), 32'd1);
    check("midrst_uo_async", 32'(uo_out), 32'h80);
    repeat (3) step();
    rst_n = 1'b1;
    wait_quiet(200, "midrst");
    check("midrst_uo_after", 32'(uo_out), 32'h80);

    // Randomized operands and strobe widths
    for (int i = 0; i < 8; i++) begin
      a = 4'($urandom_range(0, 15));
      b = 4'($urandom_range(0, 15));
      len = int'($urandom_range(1, 6));
      strobe_and_wait({b, a}, len, $sformatf("rand%0d", i));
      run_frame(8'(int'(a) + int'(b)), $sformatf("rand%0d", i), -1, 8'h00);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
